// File: rtl/uart_pkg.sv
// Shared types and constants for the 11-byte UART receive path, plus the
// combinational "COUNT:ddd" decoder used when a frame is latched.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int         FRAME_BYTES = 11;
  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [47:0] PREFIX     = 48'h434F554E543A;  // "COUNT:"

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_GAP = 2'd3;

  // Takes frame bytes 0..8 (byte 0 in the top bits); returns {valid, value}.
  function automatic logic [10:0] count_decode(input logic [71:0] f);
    logic       ok;
    logic [7:0] b;
    logic [9:0] val;
    ok  = 1'b1;
    val = '0;
    for (int i = 0; i < 6; i++) begin
      if (f[71-8*i -: 8] != PREFIX[47-8*i -: 8]) ok = 1'b0;
    end
    for (int i = 6; i < 9; i++) begin
      b = f[71-8*i -: 8];
      if (b < 8'h30 || b > 8'h39) ok = 1'b0;
      val = val * 10'd10 + {6'd0, b[3:0]};
    end
    return ok ? {1'b1, val} : 11'd0;
  endfunction

endpackage

// File: rtl/uart_ctrler.sv
// Bit-level 8N1 UART: RX samples mid-bit after a 2-flop synchroniser and
// pulses rx_done_o for one cycle per good byte; TX shifts out on a trigger.
module uart_ctrler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sclk,
  input  logic       nrst,
  input  logic       rx_i,
  input  logic       tx_trigger_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = $clog2(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_t       rx_state_q;
  logic [DW-1:0]   rx_div_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_o  <= '0;
      rx_done_o  <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_done_o <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rx_sync_q) begin
          rx_div_q   <= '0;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_div_q == HALF_LAST) begin
          rx_div_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
        end else rx_div_q <= rx_div_q + 1'b1;
        RX_DATA: if (rx_div_q == DIV_LAST) begin
          rx_div_q <= '0;
          rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end else rx_div_q <= rx_div_q + 1'b1;
        default: if (rx_div_q == DIV_LAST) begin
          // A low stop bit is a framing error: the byte is dropped.
          rx_state_q <= RX_IDLE;
          if (rx_sync_q) begin
            rx_byte_o <= rx_sh_q;
            rx_done_o <= 1'b1;
          end
        end else rx_div_q <= rx_div_q + 1'b1;
      endcase
    end
  end

  logic [9:0]    tx_sh_q;
  logic [DW-1:0] tx_div_q;
  logic [3:0]    tx_bits_q;
  logic          tx_busy_q;

  // The shifter refills with 1s, so the line idles high between frames.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      tx_sh_q   <= '1;
      tx_div_q  <= '0;
      tx_bits_q <= '0;
      tx_busy_q <= 1'b0;
    end else if (!tx_busy_q) begin
      if (tx_trigger_i) begin
        tx_sh_q   <= {1'b1, tx_byte_i, 1'b0};
        tx_div_q  <= '0;
        tx_bits_q <= '0;
        tx_busy_q <= 1'b1;
      end
    end else if (tx_div_q == DIV_LAST) begin
      tx_div_q  <= '0;
      tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
      tx_bits_q <= tx_bits_q + 1'b1;
      if (tx_bits_q == 4'd9) tx_busy_q <= 1'b0;
    end else tx_div_q <= tx_div_q + 1'b1;
  end

  assign tx_o = tx_sh_q[0];

endmodule

// File: rtl/uart_recv_11bytes.sv
// Assembles UART bytes into an 88-bit "....\r\n" frame and decodes "COUNT:ddd".
// Define UART_RECV_GAP_TIMEOUT_EN to abort frames that stall between bytes.
module uart_recv_11bytes
  import uart_pkg::*;
#(
  parameter int sys_clk_freq = 50_000_000,
  parameter int baudrate     = 115200,
  parameter int gap_bytes    = 2
) (
  input  logic        sclk,
  input  logic        nrst,
  input  logic        ch340_rx,
  output logic        ch340_tx,
  output logic [87:0] recv_11bytes,
  output logic        recv_11bytes_done,
  output logic        recv_err,
  output logic [1:0]  recv_err_code,
  output logic [9:0]  count_value,
  output logic        count_valid
);

  localparam logic [3:0] LAST_CNT = 4'(FRAME_BYTES - 1);

  logic [7:0] rx_byte;
  logic       rx_done;
  logic       gap_expired;

  uart_ctrler #(.CLK_FREQ(sys_clk_freq), .BAUD(baudrate)) u_ctrler (
    .sclk        (sclk),
    .nrst        (nrst),
    .rx_i        (ch340_rx),
    .tx_trigger_i(1'b0),
    .tx_byte_i   (8'h00),
    .tx_o        (ch340_tx),
    .rx_byte_o   (rx_byte),
    .rx_done_o   (rx_done)
  );

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [87:0] shreg_q;

`ifdef UART_RECV_GAP_TIMEOUT_EN
  localparam int GAP_MAX = gap_bytes * 10 * (sys_clk_freq / baudrate);
  logic [31:0] gap_q;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst)                             gap_q <= '0;
    else if (rx_done || state_q != RECV)   gap_q <= '0;
    else                                   gap_q <= gap_q + 1'b1;
  end

  assign gap_expired = (gap_q >= 32'(GAP_MAX));
`else
  assign gap_expired = 1'b0;
`endif

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      shreg_q           <= '0;
      recv_11bytes      <= '0;
      recv_11bytes_done <= 1'b0;
      recv_err          <= 1'b0;
      recv_err_code     <= '0;
      count_value       <= '0;
      count_valid       <= 1'b0;
    end else begin
      recv_11bytes_done <= 1'b0;
      recv_err          <= 1'b0;
      if (rx_done) shreg_q <= {shreg_q[79:0], rx_byte};
      case (state_q)
        IDLE: if (rx_done) begin
          cnt_q   <= 4'd1;
          state_q <= RECV;
        end
        RECV: if (rx_done) begin
          // shreg_q[7:0] still holds the previous byte on this edge.
          if (rx_byte == LF && shreg_q[7:0] == CR && cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end else if ((rx_byte == LF && shreg_q[7:0] == CR) || cnt_q == LAST_CNT) begin
            recv_err      <= 1'b1;
            recv_err_code <= (cnt_q == LAST_CNT) ? ERR_OVF : ERR_LEN;
            cnt_q         <= '0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else if (gap_expired) begin
          recv_err      <= 1'b1;
          recv_err_code <= ERR_GAP;
          cnt_q         <= '0;
          state_q       <= IDLE;
        end
        default: begin
          recv_11bytes                <= shreg_q;
          recv_11bytes_done           <= 1'b1;
          {count_valid, count_value}  <= count_decode(shreg_q[87:16]);
          cnt_q                       <= rx_done ? 4'd1 : 4'd0;
          state_q                     <= rx_done ? RECV : IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv_11bytes.sv
// Directed bench for uart_recv_11bytes: serialises ASCII frames onto
// ch340_rx and checks latched frame, decode, pulses and abort codes.
module tb_uart_recv_11bytes;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic        sclk = 1'b0;
  logic        nrst = 1'b0;
  logic        ch340_rx = 1'b1;
  logic        ch340_tx;
  logic [87:0] recv_11bytes;
  logic        recv_11bytes_done;
  logic        recv_err;
  logic [1:0]  recv_err_code;
  logic [9:0]  count_value;
  logic        count_valid;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int lf_cyc = 0;
  int snap_done, snap_err;
  int exp_err;

  uart_recv_11bytes #(.sys_clk_freq(CLK_FREQ), .baudrate(BAUD), .gap_bytes(2)) dut (
    .sclk             (sclk),
    .nrst             (nrst),
    .ch340_rx         (ch340_rx),
    .ch340_tx         (ch340_tx),
    .recv_11bytes     (recv_11bytes),
    .recv_11bytes_done(recv_11bytes_done),
    .recv_err         (recv_err),
    .recv_err_code    (recv_err_code),
    .count_value      (count_value),
    .count_valid      (count_valid)
  );

  // Clock / reset block
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc++;

  // Pulse monitor, sampled on the inactive edge
  always @(negedge sclk) begin
    if (recv_11bytes_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (recv_err) err_cnt++;
    if (dut.rx_done && dut.rx_byte == 8'h0A) lf_cyc = cyc;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sclk) ch340_rx = 1'b0;
    repeat (DIV - 1) @(negedge sclk);
    for (int i = 0; i < 8; i++) begin
      @(negedge sclk) ch340_rx = b[i];
      repeat (DIV - 1) @(negedge sclk);
    end
    @(negedge sclk) ch340_rx = 1'b1;
    repeat (DIV - 1) @(negedge sclk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    repeat (3 * DIV) @(negedge sclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},    {127'd0, ch340_tx}, 128'd1);
    check({tag, "_frame"}, {40'd0, recv_11bytes}, 128'd0);
    check({tag, "_pulses"}, {126'd0, recv_11bytes_done, recv_err}, 128'd0);
    check({tag, "_code"},  {126'd0, recv_err_code}, 128'd0);
    check({tag, "_count"}, {117'd0, count_valid, count_value}, 128'd0);
  endtask

  initial begin
    repeat (5) @(negedge sclk);
    check_reset_outputs("reset");
    nrst = 1'b1;
    repeat (5) @(negedge sclk);

    // Good frame
    send_str("COUNT:123\r\n");
    check("f1_done_cnt", done_cnt, 1);
    check("f1_err_cnt", err_cnt, 0);
    check("f1_frame", recv_11bytes, 88'h434F554E543A3132330D0A);
    check("f1_value", count_value, 10'd123);
    check("f1_valid", count_valid, 1'b1);
    check("f1_latency", done_cyc - lf_cyc, 2);

    // Short frame: length error, previous frame kept
    send_str("ABC\r\n");
    check("short_err_cnt", err_cnt, 1);
    check("short_code", recv_err_code, 2'd1);
    check("short_done_cnt", done_cnt, 1);
    check("short_frame_kept", recv_11bytes, 88'h434F554E543A3132330D0A);
    check("short_value_kept", count_value, 10'd123);

    send_str("COUNT:007\r\n");
    check("f007_done_cnt", done_cnt, 2);
    check("f007_value", count_value, 10'd7);
    check("f007_valid", count_valid, 1'b1);

    // Eleven bytes without terminator: overflow on the eleventh
    send_str("COUNT:99999");
    check("ovf_err_cnt", err_cnt, 2);
    check("ovf_code", recv_err_code, 2'd2);
    check("ovf_value_kept", count_value, 10'd7);
    send_str("COUNT:042\r\n");
    check("f042_value", count_value, 10'd42);
    check("f042_done_cnt", done_cnt, 3);
    check("f042_frame", recv_11bytes, 88'h434F554E543A3034320D0A);

    // Stall mid-frame for three character times
    send_str("COUNT:45");
    repeat (30 * DIV) @(negedge sclk);
    send_str("6\r\n");
`ifdef UART_RECV_GAP_TIMEOUT_EN
    exp_err = 4;
    check("gap_err_cnt", err_cnt, exp_err);
    check("gap_then_len_code", recv_err_code, 2'd1);
    check("gap_value_kept", count_value, 10'd42);
    check("gap_done_cnt", done_cnt, 3);
`else
    exp_err = 2;
    check("nogap_err_cnt", err_cnt, exp_err);
    check("nogap_value", count_value, 10'd456);
    check("nogap_done_cnt", done_cnt, 4);
`endif

    // Transport-good frame with a bad digit
    snap_done = done_cnt;
    send_str("COUNT:1A3\r\n");
    check("bad_digit_done", done_cnt, snap_done + 1);
    check("bad_digit_valid", count_valid, 1'b0);
    check("bad_digit_value", count_value, 10'd0);
    check("bad_digit_err_cnt", err_cnt, exp_err);

    // Reset after five bytes of a frame
    send_str("COUNT");
    snap_done = done_cnt;
    snap_err  = err_cnt;
    nrst = 1'b0;
    repeat (4) @(negedge sclk);
    check_reset_outputs("midreset");
    nrst = 1'b1;
    repeat (30 * DIV) @(negedge sclk);
    check("midreset_no_done", done_cnt, snap_done);
    check("midreset_no_err", err_cnt, snap_err);
    send_str("COUNT:999\r\n");
    check("post_reset_frame", recv_11bytes, 88'h434F554E543A3939390D0A);
    check("post_reset_value", count_value, 10'd999);
    check("post_reset_valid", count_valid, 1'b1);
    check("post_reset_latency", done_cyc - lf_cyc, 2);
    check("tx_idle", ch340_tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_recv_11bytes.md
Name: uart_recv_11bytes

Overview:
Receive-side counterpart of the 11-byte UART sender. It instantiates uart_ctrler for bit-level reception and assembles incoming bytes into one 88-bit frame terminated by "\r\n". It checks the frame length and, when the frame reads "COUNT:ddd\r\n", decodes the three ASCII digits to binary. It sits between the CH340 RX pin and user logic.

Parameters:
sys_clk_freq, 50_000_000, system clock frequency in Hz
baudrate, 115200, UART baud rate
gap_bytes, 2, maximum idle gap between bytes inside a frame, measured in 10-bit character times

Ports:
sclk  input  1  system clock
nrst  input  1  asynchronous active-low reset
ch340_rx  input  1  UART receive line
ch340_tx  output  1  UART transmit line; held idle high (tx_trigger tied 0)
recv_11bytes  output  88  last good frame; first received byte in [87:80]
recv_11bytes_done  output  1  one-cycle pulse when a good frame is latched
recv_err  output  1  one-cycle pulse when a frame is aborted
recv_err_code  output  2  reason for the last abort: 1 = length, 2 = overflow, 3 = gap timeout
count_value  output  10  decoded value 0..999 of the last good frame
count_valid  output  1  high when the last good frame matched "COUNT:" followed by three digits

Behaviour:
- Reset values: all outputs 0 except ch340_tx, which is 1; state IDLE; byte counter 0; shift register 0.
- Byte stream: rx_byte/rx_done come from uart_ctrler. Every rx_done shifts the byte in: shreg <= {shreg[79:0], rx_byte}; cnt <= cnt + 1.
- State IDLE: on rx_done, shift the byte in, set cnt = 1, go to RECV.
- State RECV:
  - rx_done with rx_byte = 0x0A, previous byte = 0x0D and cnt + 1 = 11 → go to DONE.
  - rx_done with 0x0A after 0x0D and cnt + 1 ≠ 11 → abort with code 1.
  - rx_done making cnt + 1 = 11 without that terminator → abort with code 2.
  - Gap counter exceeds the limit → abort with code 3.
- State DONE (one cycle):
  - recv_11bytes <= shreg.
  - recv_11bytes_done = 1.
  - count_value and count_valid are updated in the same cycle.
  - Return to IDLE.
  - Latency: done is asserted 2 sclk cycles after the rx_done of the final 0x0A.
- Abort: recv_err pulses for 1 cycle and recv_err_code is updated. recv_11bytes, count_value and count_valid are unchanged. cnt <= 0, return to IDLE. Resynchronisation is implicit: the next byte starts a new frame.
- Decode:
  - Prefix bytes 0..5 must equal "COUNT:" (0x43 0x4F 0x55 0x4E 0x54 0x3A).
  - Bytes 6..8 must each be in 0x30..0x39.
  - count_value = d0*100 + d1*10 + d2, computed in 10 bits with no overflow possible.
  - If the prefix or any digit is wrong, count_valid = 0 and count_value = 0, but done still pulses (the frame is good at transport level).
- Gap counter:
  - Limit GAP_MAX = gap_bytes * 10 * (sys_clk_freq / baudrate) cycles.
  - Counts only in RECV; cleared on every rx_done.
  - rx_done on the same cycle as expiry: the byte wins and the counter clears.
- Reset mid-frame: the partial frame is discarded immediately and no done or err pulse is produced.
- The rx_done pulse is 1 cycle wide; back-to-back bytes are handled with no dead cycle.

Optional Feature:
Macro: UART_RECV_GAP_TIMEOUT_EN.
- Defined: the gap counter and error code 3 are present as described above.
- Undefined: no gap counter is instantiated, a partial frame waits indefinitely, and code 3 is never produced.

Decomposition:
- Package uart_pkg holds:
  - state encoding (IDLE, RECV, DONE);
  - FRAME_BYTES = 11;
  - ASCII constants CR = 0x0D, LF = 0x0A;
  - the prefix "COUNT:";
  - error codes ERR_LEN = 1, ERR_OVF = 2, ERR_GAP = 3.
- Sub-module: reuse the existing uart_ctrler for bit-level RX.
- A small combinational helper, count_frame_decode, takes the 88-bit frame and returns count_value and count_valid; it is optional as a separate module.

Test Plan:
- Send "COUNT:123\r\n" at 115200 baud → recv_11bytes = 0x434F554E543A3132330D0A, done pulses once, count_value = 123, count_valid = 1, recv_err stays 0.
- Send "ABC\r\n" → recv_err pulse, code 1; prior frame and count_value are unchanged. A following "COUNT:007\r\n" → count_value = 7.
- Send 11 bytes "COUNT:99999" with no terminator → error code 2 on the 11th byte. The next valid frame is received correctly.
- Send "COUNT:45", then idle 3 character times (macro defined) → error code 3. With the macro undefined, nothing fires, and "6\r\n" afterwards completes the frame with count_value = 456.
- Send "COUNT:1A3\r\n" → done pulses, count_valid = 0, count_value = 0.
- Assert nrst low after 5 bytes of a frame → no pulses, all outputs at reset values. A full frame after release decodes correctly.
